// File: rtl/fixed_point_seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per cycle through a
// ripple-borrow trial subtractor, with valid/ready request and result ports.
module fixed_point_seq_divider #(
  parameter int unsigned N     = 32,
  parameter              MODEL = "DataFlow"
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  d_q, d_nxt;
  logic [N-1:0]  q_q, q_nxt;
  logic [N:0]    r_q, r_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic          dz_pend, dz_pend_nxt;
  logic [N-1:0]  quo_nxt, rem_nxt;
  logic          dz_nxt;

  logic [N:0]    t;
  logic [N:0]    sub_b;
  logic [N:0]    diff;
  logic          borrow;
  logic          unused_r_msb;

  // Partial remainder shifted left with the next dividend bit brought in.
  assign t            = {r_q[N-1:0], q_q[N-1]};
  assign sub_b        = {1'b0, d_q};
  // The top bit of R is always zero once the restore step has run.
  assign unused_r_msb = r_q[N];

  if (MODEL == "DataFlow") begin : g_ripple
    logic [N+1:0] brw;
    assign brw[0] = 1'b0;
    for (genvar i = 0; i < N + 1; i++) begin : g_bit
      // Full-subtractor cell: difference and borrow-out.
      assign diff[i]  = t[i] ^ sub_b[i] ^ brw[i];
      assign brw[i+1] = (~t[i] & sub_b[i]) | (~(t[i] ^ sub_b[i]) & brw[i]);
    end
    assign borrow = brw[N+1];
  end else begin : g_behav
    assign {borrow, diff} = {1'b0, t} - {1'b0, sub_b};
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Next-state and datapath update.
  always_comb begin
    state_nxt   = state;
    d_nxt       = d_q;
    q_nxt       = q_q;
    r_nxt       = r_q;
    cnt_nxt     = cnt_q;
    dz_pend_nxt = dz_pend;
    quo_nxt     = quotient;
    rem_nxt     = remainder;
    dz_nxt      = div_by_zero;
    case (state)
      IDLE: begin
        if (in_valid) begin
          d_nxt       = divisor;
          q_nxt       = dividend;
          r_nxt       = '0;
          cnt_nxt     = '0;
          dz_pend_nxt = (divisor == '0);
          state_nxt   = BUSY;
        end
      end
      BUSY: begin
        if (dz_pend) begin
          // Zero divisor: a single cycle here, then publish the fixed result.
          quo_nxt   = '1;
          rem_nxt   = q_q;
          dz_nxt    = 1'b1;
          state_nxt = DONE;
        end else begin
          r_nxt   = borrow ? t : diff;
          q_nxt   = {q_q[N-2:0], ~borrow};
          cnt_nxt = cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            quo_nxt   = {q_q[N-2:0], ~borrow};
            rem_nxt   = borrow ? t[N-1:0] : diff[N-1:0];
            dz_nxt    = 1'b0;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, working registers and held result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      d_q         <= '0;
      q_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      dz_pend     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_nxt;
      d_q         <= d_nxt;
      q_q         <= q_nxt;
      r_q         <= r_nxt;
      cnt_q       <= cnt_nxt;
      dz_pend     <= dz_pend_nxt;
      quotient    <= quo_nxt;
      remainder   <= rem_nxt;
      div_by_zero <= dz_nxt;
    end
  end

endmodule

// File: tb/tb_fixed_point_seq_divider.sv
// Bench for fixed_point_seq_divider: directed N=8 vectors and corner sequences,
// plus a scoreboarded random regression on an N=32 instance.
module tb_fixed_point_seq_divider;

  localparam int unsigned NA   = 8;
  localparam int unsigned NB   = 32;
  localparam int          NOPS = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N=8 instance
  logic          a_rst_n, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_dz;
  logic [NA-1:0] a_dividend, a_divisor, a_quotient, a_remainder;
  // N=32 instance
  logic          b_rst_n, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_dz;
  logic [NB-1:0] b_dividend, b_divisor, b_quotient, b_remainder;

  fixed_point_seq_divider #(.N(NA), .MODEL("DataFlow")) dut_a (
    .clk(clk), .rst_n(a_rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .dividend(a_dividend), .divisor(a_divisor), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .quotient(a_quotient), .remainder(a_remainder),
    .div_by_zero(a_dz)
  );

  fixed_point_seq_divider #(.N(NB), .MODEL("DataFlow")) dut_b (
    .clk(clk), .rst_n(b_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .dividend(b_dividend), .divisor(b_divisor), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .quotient(b_quotient), .remainder(b_remainder),
    .div_by_zero(b_dz)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] dvd;
    logic [7:0] dvs;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         lat;
  } vec_t;

  typedef struct {
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } res_t;

  vec_t vecs[8];
  res_t sb[$];
  res_t exp_r;
  int   done_cnt;
  int   cyc;
  int   drv_done;
  int   lat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic res_t ref_div(input logic [31:0] dvd, input logic [31:0] dvs);
    res_t o;
    o.dvd = dvd;
    o.dvs = dvs;
    if (dvs == 32'd0) begin
      o.q  = 32'hFFFF_FFFF;
      o.r  = dvd;
      o.dz = 1'b1;
    end else begin
      o.q  = dvd / dvs;
      o.r  = dvd % dvs;
      o.dz = 1'b0;
    end
    return o;
  endfunction

  // One request on the N=8 instance; called one step after an edge with the DUT idle.
  task automatic run8(input vec_t v, input string tag);
    int l;
    check($sformatf("%s_in_ready", tag), 64'(a_in_ready), 64'(1));
    a_in_valid  = 1'b1;
    a_dividend  = v.dvd;
    a_divisor   = v.dvs;
    a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    a_dividend = 8'($urandom);
    a_divisor  = 8'($urandom);
    l = 0;
    while (!a_out_valid && l < 64) begin
      tick();
      l++;
    end
    check($sformatf("%s_latency", tag), 64'(l), 64'(v.lat));
    check($sformatf("%s_quotient", tag), 64'(a_quotient), 64'(v.q));
    check($sformatf("%s_remainder", tag), 64'(a_remainder), 64'(v.r));
    check($sformatf("%s_dz", tag), 64'(a_dz), 64'(v.dz));
    tick();
    check($sformatf("%s_ready_after", tag), 64'({a_in_ready, a_out_valid}), 64'(2'b10));
  endtask

  initial begin
    vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 8};
    vecs[1] = '{8'h5A,  8'd0,   8'hFF,  8'h5A,  1'b1, 1};
    vecs[2] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 8};
    vecs[3] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 8};
    vecs[4] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 8};
    vecs[5] = '{8'd0,   8'd3,   8'd0,   8'd0,   1'b0, 8};
    vecs[6] = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1, 1};
    vecs[7] = '{8'd200, 8'd13,  8'd15,  8'd5,   1'b0, 8};

    a_rst_n = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1; a_dividend = '0; a_divisor = '0;
    b_rst_n = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1; b_dividend = '0; b_divisor = '0;
    #12;
    check("rst_a_flags", 64'({a_in_ready, a_out_valid}), 64'(2'b10));
    check("rst_a_outputs", 64'({a_quotient, a_remainder, a_dz}), 64'(0));
    check("rst_b_flags", 64'({b_in_ready, b_out_valid}), 64'(2'b10));
    @(negedge clk);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    tick();

    // Directed table on the N=8 instance.
    for (int i = 0; i < 8; i++) run8(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result held in DONE while extra requests are ignored.
    a_in_valid = 1'b1; a_dividend = 8'd100; a_divisor = 8'd7; a_out_ready = 1'b0;
    tick();
    a_in_valid = 1'b0;
    lat = 0;
    while (!a_out_valid && lat < 64) begin
      tick();
      lat++;
    end
    check("bp_latency", 64'(lat), 64'(8));
    for (int k = 0; k < 5; k++) begin
      a_in_valid = 1'b1; a_dividend = 8'd200; a_divisor = 8'd13;
      tick();
      check($sformatf("bp_hold%0d_flags", k), 64'({a_out_valid, a_in_ready}), 64'(2'b10));
      check($sformatf("bp_hold%0d_result", k), 64'({a_quotient, a_remainder, a_dz}),
            64'({8'd14, 8'd2, 1'b0}));
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    tick();
    check("bp_release_flags", 64'({a_in_ready, a_out_valid}), 64'(2'b10));
    check("bp_retained", 64'({a_quotient, a_remainder}), 64'({8'd14, 8'd2}));
    tick();
    check("bp_no_stray_accept", 64'({a_in_ready, a_out_valid}), 64'(2'b10));

    // Reset during iteration 4 of 100/7, then a fresh request.
    a_in_valid = 1'b1; a_dividend = 8'd100; a_divisor = 8'd7;
    tick();
    a_in_valid = 1'b0;
    repeat (4) tick();
    check("midrst_busy", 64'({a_in_ready, a_out_valid}), 64'(2'b00));
    #1 a_rst_n = 1'b0;
    #1;
    check("midrst_flags", 64'({a_in_ready, a_out_valid}), 64'(2'b10));
    check("midrst_outputs", 64'({a_quotient, a_remainder, a_dz}), 64'(0));
    @(negedge clk);
    a_rst_n = 1'b1;
    tick();
    run8(vecs[7], "post_rst");

    // Random regression on the N=32 instance with a scoreboard.
    done_cnt = 0;
    cyc      = 0;
    drv_done = 0;
    fork
      begin : driver
        logic [31:0] dvd, dvs;
        int w;
        for (int i = 0; i < NOPS; i++) begin
          case ($urandom_range(0, 7))
            0:       begin dvd = $urandom; dvs = 32'd0; end
            1:       begin dvd = $urandom; dvs = 32'($urandom_range(1, 15)); end
            2:       begin dvd = 32'($urandom_range(0, 255)); dvs = $urandom; end
            default: begin dvd = $urandom; dvs = $urandom >> $urandom_range(0, 31); end
          endcase
          w = 0;
          while (!b_in_ready && w < 200) begin
            tick();
            w++;
          end
          if (!b_in_ready) begin
            check("rand_accept_timeout", 64'(0), 64'(1));
            break;
          end
          b_in_valid = 1'b1; b_dividend = dvd; b_divisor = dvs;
          @(posedge clk);
          sb.push_back(ref_div(dvd, dvs));
          #1;
          b_in_valid = 1'b0;
          b_dividend = $urandom;
          b_divisor  = $urandom;
          repeat ($urandom_range(0, 2)) tick();
        end
        drv_done = 1;
      end
      begin : monitor
        while (done_cnt < NOPS && cyc < 60000 && !(drv_done != 0 && sb.size() == 0)) begin
          tick();
          cyc++;
          b_out_ready = ($urandom_range(0, 3) != 0);
          if (b_out_valid && b_out_ready) begin
            if (sb.size() == 0) begin
              check("rand_unexpected_result", 64'(1), 64'(0));
            end else begin
              exp_r = sb.pop_front();
              check($sformatf("rand%0d_quotient", done_cnt), 64'(b_quotient), 64'(exp_r.q));
              check($sformatf("rand%0d_remainder", done_cnt), 64'(b_remainder), 64'(exp_r.r));
              check($sformatf("rand%0d_dz", done_cnt), 64'(b_dz), 64'(exp_r.dz));
              if (!exp_r.dz) begin
                check($sformatf("rand%0d_identity", done_cnt),
                      64'(b_quotient) * 64'(exp_r.dvs) + 64'(b_remainder), 64'(exp_r.dvd));
                check($sformatf("rand%0d_rem_lt_div", done_cnt),
                      64'(b_remainder < exp_r.dvs), 64'(1));
              end
            end
            done_cnt++;
          end
        end
      end
    join
    check("rand_results_count", 64'(done_cnt), 64'(NOPS));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
